// File: rtl/mulop_pkg.sv
// Shared types and limits for the mulop_pipe arithmetic pipeline.
package mulop_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'd0,
    OpAdd    = 2'd1,
    OpMac    = 2'd2,
    OpClrAcc = 2'd3
  } op_t;

  localparam int unsigned STAGES_MAX = 4;

endpackage

// File: rtl/mulop_stage.sv
// One pipeline register holding valid, result and overflow flag; holds when en_i is low.
module mulop_stage
  import mulop_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [N-1:0] out_i,
  input  logic         ovf_i,
  output logic         valid_o,
  output logic [N-1:0] out_o,
  output logic         ovf_o
);

  logic         valid_d, valid_q;
  logic [N-1:0] out_d, out_q;
  logic         ovf_d, ovf_q;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    if (en_i) begin
      valid_d = valid_i;
      out_d   = out_i;
      ovf_d   = ovf_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign out_o   = out_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/mult.sv
// Signed W x W -> 2W multiplier; p selects internal pipelining, only p = 0 is provided here.
module mult #(
  parameter int unsigned W = 8,
  parameter int unsigned p = 0
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] prod_o
);

  if (p != 0) begin : g_p_check
    $error("mult: only the combinational variant (p = 0) is available");
  end

  assign prod_o = a_i * b_i;

endmodule

// File: rtl/mulop_pipe.sv
// Pipelined signed MUL/ADD/MAC/CLRACC unit with accumulator and overflow flag.
// Define MULOP_SAT_EN to saturate out-of-range results instead of wrapping them.
module mulop_pipe
  import mulop_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [1:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Out,
  output logic         Ovf
);

  localparam int unsigned XW = 2 * N + 1;
  localparam logic signed [XW-1:0] MaxV = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [XW-1:0] MinV = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

  if (STAGES < 1 || STAGES > STAGES_MAX || N < 4 || N > 32) begin : g_param_check
    $error("mulop_pipe: parameter out of range");
  end

  op_t  op;
  logic stall, accept;

  assign op      = op_t'(Op);
  assign stall   = OutValid && !OutReady;
  assign InReady = !stall;
  assign accept  = InValid && InReady;

  logic signed [N-1:0]   acc_d, acc_q;
  logic signed [N-1:0]   mul_b;
  logic signed [2*N-1:0] prod;

  // ADD reuses the multiplier: A * 1 plus B on the accumulate path.
  assign mul_b = (op == OpAdd) ? {{(N - 1){1'b0}}, 1'b1} : B;

  mult #(
    .W (N),
    .p (0)
  ) u_mult (
    .a_i    (A),
    .b_i    (mul_b),
    .prod_o (prod)
  );

  logic signed [XW-1:0] addend, exact;
  logic                 ovf_raw;
  logic [N-1:0]         red, res_out;
  logic                 res_ovf;

  always_comb begin
    case (op)
      OpAdd:   addend = {{(N + 1){B[N-1]}}, B};
      OpMac:   addend = {{(N + 1){acc_q[N-1]}}, acc_q};
      default: addend = '0;
    endcase
    exact   = {prod[2*N-1], prod} + addend;
    ovf_raw = (exact > MaxV) || (exact < MinV);
`ifdef MULOP_SAT_EN
    if (ovf_raw) begin
      red = exact[XW-1] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
    end else begin
      red = exact[N-1:0];
    end
`else
    red = exact[N-1:0];
`endif
    res_out = red;
    res_ovf = ovf_raw;
    if (op == OpClrAcc) begin
      res_out = '0;
      res_ovf = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      if (op == OpMac)    acc_d = red;
      if (op == OpClrAcc) acc_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  logic [STAGES:0]        st_valid, st_ovf;
  logic [STAGES:0][N-1:0] st_out;

  assign st_valid[0] = InValid;
  assign st_out[0]   = res_out;
  assign st_ovf[0]   = res_ovf;

  // All stages share one enable so a stall freezes the whole pipe, bubbles included.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mulop_stage #(
      .N (N)
    ) u_stage (
      .clk_i   (Clock),
      .rst_ni  (nReset),
      .en_i    (InReady),
      .valid_i (st_valid[i]),
      .out_i   (st_out[i]),
      .ovf_i   (st_ovf[i]),
      .valid_o (st_valid[i+1]),
      .out_o   (st_out[i+1]),
      .ovf_o   (st_ovf[i+1])
    );
  end

  assign OutValid = st_valid[STAGES];
  assign Out      = st_out[STAGES];
  assign Ovf      = st_ovf[STAGES];

endmodule

// File: tb/tb_mulop_pipe.sv
// Self-checking bench for mulop_pipe (N=8, STAGES=2): directed cases plus a random scoreboard run.
module tb_mulop_pipe;

  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int MaxI   = 127;
  localparam int MinI   = -128;

`ifdef MULOP_SAT_EN
  localparam logic [N-1:0] EMul16 = 8'h7F;
  localparam logic [N-1:0] EAdd100 = 8'h7F;
`else
  localparam logic [N-1:0] EMul16 = 8'h00;
  localparam logic [N-1:0] EAdd100 = 8'hC8;
`endif

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [1:0]   Op = 2'd0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         OutValid;
  logic         OutReady = 1'b1;
  logic [N-1:0] Out;
  logic         Ovf;

  mulop_pipe #(
    .N      (N),
    .STAGES (STAGES)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Out      (Out),
    .Ovf      (Ovf)
  );

  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_xfer = 0;
  int acc_m  = 0;
  bit rand_rdy = 1'b0;

  logic [N:0]   exp_q[$];
  logic [N-1:0] log_out[$];
  int           log_cyc[$];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic evaluated at acceptance, results queued in order.
  always @(negedge Clock) begin
    int a, b, x, r;
    logic ov;
    logic signed [N-1:0] r8;
    logic [N:0] e;
    if (!nReset) begin
      exp_q.delete();
      acc_m = 0;
    end else begin
      if (OutValid && OutReady) begin
        log_out.push_back(Out);
        log_cyc.push_back(cyc);
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("sb_result_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", {23'd0, Ovf, Out}, {23'd0, e});
        end
      end
      if (InValid && InReady) begin
        a = int'($signed(A));
        b = int'($signed(B));
        case (Op)
          2'd0:    x = a * b;
          2'd1:    x = a + b;
          2'd2:    x = acc_m + a * b;
          default: x = 0;
        endcase
        ov = (x > MaxI) || (x < MinI);
`ifdef MULOP_SAT_EN
        r = ov ? ((x < 0) ? MinI : MaxI) : x;
`else
        r = x;
`endif
        r8 = r[N-1:0];
        if (Op == 2'd2) acc_m = int'(r8);
        if (Op == 2'd3) acc_m = 0;
        exp_q.push_back({ov, r[N-1:0]});
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
    if (rand_rdy) OutReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    bit ok;
    int k;
    ok = 1'b0;
    k  = 0;
    InValid = 1'b1;
    Op = op;
    A  = a;
    B  = b;
    while (!ok && k < 50) begin
      @(negedge Clock);
      ok = InReady;
      tick();
      k++;
    end
    if (!ok) check("send_accept_timeout", 32'(ok), 32'd1);
    InValid = 1'b0;
  endtask

  task automatic expect_next(input string tag, input logic [N-1:0] eo, input logic eovf);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 10) begin
      @(negedge Clock);
      seen = OutValid;
      k++;
    end
    check({tag, "_valid"}, 32'(OutValid), 32'd1);
    check({tag, "_out"}, 32'(Out), 32'(eo));
    check({tag, "_ovf"}, 32'(Ovf), 32'(eovf));
    tick();
  endtask

  initial begin
    int base, x0;
    logic [N-1:0] held;
    logic [N-1:0] chain_exp[4];
    chain_exp[0] = 8'h00;
    chain_exp[1] = 8'h0C;
    chain_exp[2] = 8'h02;
    chain_exp[3] = 8'h31;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    #2 nReset = 1'b1;
    tick();

    // MUL 12*10: not valid one cycle after acceptance, valid the cycle after that.
    send(2'd0, 8'd12, 8'd10);
    check("lat_t1_valid", 32'(OutValid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(OutValid), 32'd1);
    check("lat_t2_out", 32'(Out), 32'h78);
    check("lat_t2_ovf", 32'(Ovf), 32'd0);
    repeat (2) tick();

    send(2'd0, 8'd16, 8'd16);
    expect_next("mul_ovf", EMul16, 1'b1);
    send(2'd1, 8'd100, 8'd100);
    expect_next("add_ovf", EAdd100, 1'b1);

    // Back-to-back accumulator chain.
    base = log_out.size();
    send(2'd3, 8'd0, 8'd0);
    send(2'd2, 8'd3, 8'd4);
    send(2'd2, 8'hFB, 8'd2);
    send(2'd0, 8'd7, 8'd7);
    repeat (4) tick();
    check("chain_count", 32'(log_out.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("chain_out%0d", k), 32'(log_out[base+k]), 32'(chain_exp[k]));
      check($sformatf("chain_cyc%0d", k), 32'(log_cyc[base+k] - log_cyc[base]), 32'(k));
    end
    send(2'd2, 8'd0, 8'd0);
    expect_next("acc_after_chain", 8'h02, 1'b0);

    // Stall with four ops in the stream.
    x0 = n_xfer;
    OutReady = 1'b0;
    send(2'd0, 8'd3, 8'd5);
    send(2'd1, 8'd9, 8'd8);
    held = Out;
    InValid = 1'b1;
    Op = 2'd2;
    A  = 8'd2;
    B  = 8'd2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_inready%0d", k), 32'(InReady), 32'd0);
      check($sformatf("stall_valid%0d", k), 32'(OutValid), 32'd1);
      check($sformatf("stall_out%0d", k), 32'(Out), 32'(held));
      tick();
    end
    OutReady = 1'b1;
    send(2'd2, 8'd2, 8'd2);
    send(2'd0, 8'hFD, 8'd4);
    repeat (6) tick();
    check("stall_delivered", 32'(n_xfer - x0), 32'd4);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two ops in flight.
    send(2'd0, 8'd5, 8'd5);
    send(2'd0, 8'd6, 8'd6);
    #1 nReset = 1'b0;
    #1;
    check("rst_async_valid", 32'(OutValid), 32'd0);
    check("rst_async_out", 32'(Out), 32'd0);
    check("rst_async_inready", 32'(InReady), 32'd1);
    repeat (2) tick();
    nReset = 1'b1;
    x0 = n_xfer;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst_valid%0d", k), 32'(OutValid), 32'd0);
    end
    check("post_rst_no_stale", 32'(n_xfer - x0), 32'd0);
    send(2'd2, 8'd2, 8'd3);
    expect_next("mac_after_reset", 8'h06, 1'b0);

    // Random traffic with random back-pressure and input gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    rand_rdy = 1'b0;
    OutReady = 1'b1;
    repeat (8) tick();
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
